// File: rtl/noc_inject_ni.sv
// noc_inject_ni: injection NI turning host packet requests into credit-controlled flits for one router input port.
// Define NI_STATS_EN to add the stat_pkts/stat_flits counters.
`ifndef ARRAYW
`define ARRAYW 1
`endif
`ifndef VCHW
`define VCHW 0
`endif
`ifndef VCH
`define VCH 1
`endif
`ifndef DATAW
`define DATAW 32
`endif

module noc_inject_ni #(
   parameter int BUF_DEPTH = 4,
   parameter int MAX_LEN   = 15
) (
   input  logic              clk,
   input  logic              rst_,
   input  logic [`ARRAYW:0]  my_xpos,
   input  logic [`ARRAYW:0]  my_ypos,
   input  logic              hreq_valid,
   output logic              hreq_ready,
   input  logic [`ARRAYW:0]  hreq_dstx,
   input  logic [`ARRAYW:0]  hreq_dsty,
   input  logic [`VCHW:0]    hreq_vch,
   input  logic [3:0]        hreq_len,
   input  logic              hdat_valid,
   output logic              hdat_ready,
   input  logic [`DATAW-1:0] hdat,
   output logic [`DATAW+1:0] odata,
   output logic              ovalid,
   output logic [`VCHW:0]    ovch,
   input  logic [`VCH:0]     iack,
   input  logic [`VCH:0]     ilck
`ifdef NI_STATS_EN
   ,
   output logic [15:0]       stat_pkts,
   output logic [15:0]       stat_flits
`endif
);
   localparam int CW = $clog2(BUF_DEPTH + 1);
   localparam int NV = `VCH + 1;
   localparam int AW = `ARRAYW + 1;

   typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;

   state_t            state, state_nx;
   logic [AW-1:0]     dst_x, dst_y;
   logic [`VCHW:0]    vch;
   logic [3:0]        len, remaining;
   logic [CW-1:0]     credit [NV];
   logic [NV-1:0]     dec;
   logic              accept, has_credit, send_head, send_body, send;
   logic [`DATAW+1:0] flit;

   assign accept     = hreq_valid && hreq_ready;
   assign has_credit = credit[vch] != '0;
   assign hreq_ready = rst_ && state == IDLE;
   assign hdat_ready = state == BODY && has_credit;
   assign send_head  = state == HEAD && has_credit && !ilck[vch];
   assign send_body  = hdat_valid && hdat_ready;
   assign send       = send_head || send_body;
   assign dec        = send ? NV'(1) << vch : '0;
   assign flit       = send_head ? {len == 4'd0 ? 2'b11 : 2'b01, {(`DATAW - 4 * AW){1'b0}}, my_ypos, my_xpos, dst_y, dst_x}
                                 : {remaining == 4'd1 ? 2'b10 : 2'b00, hdat};

   always_ff @(posedge clk or negedge rst_)
      if (!rst_) state <= IDLE;
      else state <= state_nx;

   always_comb begin
      state_nx = state;
      if (accept) state_nx = HEAD;
      else if (send_head) state_nx = len == 4'd0 ? IDLE : BODY;
      else if (send_body && remaining == 4'd1) state_nx = IDLE;
   end

   always_ff @(posedge clk or negedge rst_)
      if (!rst_) begin
         odata     <= '0;
         ovalid    <= 1'b0;
         ovch      <= '0;
         dst_x     <= '0;
         dst_y     <= '0;
         vch       <= '0;
         len       <= '0;
         remaining <= '0;
      end else begin
         ovalid <= send;
         if (send) begin
            odata <= flit;
            ovch  <= vch;
         end
         if (accept) begin
            dst_x <= hreq_dstx;
            dst_y <= hreq_dsty;
            vch   <= hreq_vch;
            len   <= hreq_len > 4'(MAX_LEN) ? 4'(MAX_LEN) : hreq_len;
         end
         if (send_head) remaining <= len;
         else if (send_body) remaining <= remaining - 4'd1;
      end

   // A send and a returned credit on the same VC cancel out; a surplus iack saturates.
   always_ff @(posedge clk or negedge rst_)
      if (!rst_) begin
         for (int i = 0; i < NV; i++) credit[i] <= CW'(BUF_DEPTH);
      end else begin
         for (int i = 0; i < NV; i++)
            if (dec[i] && !iack[i]) credit[i] <= credit[i] - CW'(1);
            else if (iack[i] && !dec[i] && credit[i] != CW'(BUF_DEPTH)) credit[i] <= credit[i] + CW'(1);
      end

`ifndef SYNTHESIS
   always @(posedge clk)
      for (int i = 0; i < NV; i++)
         if (rst_ && iack[i] && !dec[i] && credit[i] == CW'(BUF_DEPTH))
            $display("noc_inject_ni: iack on vc %0d while credit already full", i);
`endif

`ifdef NI_STATS_EN
   always_ff @(posedge clk or negedge rst_)
      if (!rst_) begin
         stat_pkts  <= '0;
         stat_flits <= '0;
      end else begin
         if (send_head) stat_pkts <= stat_pkts + 16'd1;
         if (send) stat_flits <= stat_flits + 16'd1;
      end
`endif

endmodule
